router_inject_arbiter: RTL



---
 rtl/router_inject_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/router_inject_arbiter.sv
// Packet-level round-robin arbiter sharing one router injection port, with per-VC credit tracking.
// Optional INJ_FLIT_COUNT_EN adds a saturating 16-bit transfer counter output (flit_count).
module router_inject_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int FLIT_W    = 68,
  parameter int BUF_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*(FLIT_W-1)-1:0]   req_flit,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [FLIT_W-1:0]               chan_out,
  input  logic [1:0]                      flow_ctrl_in,
  output logic                            error
`ifdef INJ_FLIT_COUNT_EN
  ,
  output logic [15:0]                     flit_count
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SLICE_W = FLIT_W - 1;
  localparam logic [3:0] CRED_MAX = 4'(BUF_DEPTH);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   rr_ptr_reg;
  logic [IDX_W-1:0]   owner_reg;
  logic [3:0]         credit_reg [2];
  logic [FLIT_W-1:0]  chan_reg;
  logic               error_reg;

  logic [SLICE_W-1:0] slice [NUM_REQ];
  logic [NUM_REQ-1:0] req_vc;
  logic [NUM_REQ-1:0] req_head;
  logic [NUM_REQ-1:0] eligible;

  // Field {vc, head, tail, payload} unpacking per requester
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign slice[gi]    = req_flit[gi*SLICE_W +: SLICE_W];
    assign req_vc[gi]   = slice[gi][SLICE_W-1];
    assign req_head[gi] = slice[gi][SLICE_W-2];
    assign eligible[gi] = req_valid[gi] && req_head[gi] && (credit_reg[req_vc[gi]] != 4'd0);
  end

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  int               scan_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(rr_ptr_reg) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!win_found && eligible[IDX_W'(scan_idx)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(scan_idx);
      end
    end
  end

  logic               xfer;
  logic [IDX_W-1:0]   sel_idx;
  logic [SLICE_W-1:0] sel_flit;
  logic               sel_vc;
  logic               sel_head;
  logic               sel_tail;

  always_comb begin
    req_ready = '0;
    xfer      = 1'b0;
    sel_idx   = owner_reg;
    case (state_reg)
      IDLE: begin
        sel_idx = win_idx;
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          xfer               = 1'b1;
        end
      end
      LOCKED: begin
        if (req_valid[owner_reg] && (credit_reg[req_vc[owner_reg]] != 4'd0)) begin
          req_ready[owner_reg] = 1'b1;
          xfer                 = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign sel_flit = slice[sel_idx];
  assign sel_vc   = sel_flit[SLICE_W-1];
  assign sel_head = sel_flit[SLICE_W-2];
  assign sel_tail = sel_flit[SLICE_W-3];

  logic [3:0] credit_next [2];
  logic [1:0] cred_ovf;
  logic       cred_dec;
  logic       cred_inc;

  // Simultaneous consume and return on one VC cancel out
  always_comb begin
    cred_ovf = '0;
    cred_dec = 1'b0;
    cred_inc = 1'b0;
    for (int v = 0; v < 2; v++) begin
      cred_dec       = xfer && (sel_vc == 1'(v));
      cred_inc       = flow_ctrl_in[1] && (flow_ctrl_in[0] == 1'(v));
      credit_next[v] = credit_reg[v];
      if (cred_dec && !cred_inc) begin
        credit_next[v] = credit_reg[v] - 4'd1;
      end else if (cred_inc && !cred_dec) begin
        if (credit_reg[v] == CRED_MAX) cred_ovf[v] = 1'b1;
        else credit_next[v] = credit_reg[v] + 4'd1;
      end
    end
  end

`ifdef INJ_FLIT_COUNT_EN
  logic [15:0] flit_count_reg;
  assign flit_count = flit_count_reg;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      owner_reg     <= '0;
      credit_reg[0] <= CRED_MAX;
      credit_reg[1] <= CRED_MAX;
      chan_reg      <= '0;
      error_reg     <= 1'b0;
`ifdef INJ_FLIT_COUNT_EN
      flit_count_reg <= '0;
`endif
    end else begin
      chan_reg      <= xfer ? {1'b1, sel_flit} : '0;
      credit_reg[0] <= credit_next[0];
      credit_reg[1] <= credit_next[1];
      // A head flit from the current owner is a protocol error but still forwarded
      error_reg <= error_reg || (|cred_ovf) || ((state_reg == LOCKED) && xfer && sel_head);
`ifdef INJ_FLIT_COUNT_EN
      if (xfer && (flit_count_reg != 16'hFFFF)) flit_count_reg <= flit_count_reg + 16'd1;
`endif
      case (state_reg)
        IDLE: begin
          if (xfer) begin
            if (sel_tail) begin
              rr_ptr_reg <= ptr_inc(win_idx);
            end else begin
              owner_reg <= win_idx;
              state_reg <= LOCKED;
            end
          end
        end
        LOCKED: begin
          if (xfer && sel_tail) begin
            rr_ptr_reg <= ptr_inc(owner_reg);
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign chan_out = chan_reg;
  assign error    = error_reg;

endmodule
